// File: rtl/npu_feature_pkg.sv
// Shared definitions for the depthwise feature packing path.
// Holds the array geometry (lanes, feature width, IO-buffer address width),
// the fill-counter width and the fill FSM state encoding.
package npu_feature_pkg;

  localparam int PE_COL_NUM = 8;
  localparam int DATA_W     = 8;
  localparam int ADDR_W     = 13;
  localparam int CNT_W      = 4;                  // holds 0..PE_COL_NUM
  localparam int VEC_W      = PE_COL_NUM * DATA_W;

  typedef enum logic {
    COLLECT = 1'b0,
    COMMIT  = 1'b1
  } fill_state_t;

endpackage

// File: rtl/feature_tag_delay.sv
// Delays the per-beat tag {beat, pad, end} by RD_LAT cycles so it lines up
// with the IO-buffer read data.
// Ports:
//   clk, rst          clock, asynchronous active-high reset
//   i_flush           synchronous clear of every stage
//   i_beat/i_pad/i_end  tag entering the pipeline
//   o_beat/o_pad/o_end  tag leaving the pipeline, RD_LAT cycles later
module feature_tag_delay #(
  parameter int RD_LAT = 1
) (
  input  logic clk,
  input  logic rst,
  input  logic i_flush,
  input  logic i_beat,
  input  logic i_pad,
  input  logic i_end,
  output logic o_beat,
  output logic o_pad,
  output logic o_end
);

  generate
    for (genvar gi = 0; gi < RD_LAT; gi++) begin : g_stage
      logic [2:0] r_q;
      logic [2:0] w_d;

      if (gi == 0) begin : g_first
        assign w_d = {i_beat, i_pad, i_end};
      end else begin : g_chain
        assign w_d = g_stage[gi-1].r_q;
      end

      always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
          r_q <= '0;
        end else if (i_flush) begin
          r_q <= '0;
        end else begin
          r_q <= w_d;
        end
      end
    end
  endgenerate

  assign {o_beat, o_pad, o_end} = g_stage[RD_LAT-1].r_q;

endmodule

// File: rtl/depth_feature_packer.sv
// Turns address-generator beats into IO-buffer reads (or zeros for padding),
// packs the returned features lane by lane into a PE_COL_NUM-wide vector and
// hands each completed group to the PE array through a 2-slot FIFO.
// Ports:
//   clk, rst                 clock, asynchronous active-high reset
//   i_start                  synchronous flush of all state
//   i_d_addr/i_rd_en/i_pad_en/i_feature_end   beat stream from the address generator
//   o_buf_addr/o_buf_rd_en/i_buf_rdata        IO-buffer read port
//   o_vec_data/o_vec_lanes/o_vec_valid/i_vec_ready  group output (valid/ready)
//   o_full                   both slots occupied (registered)
//   o_err                    sticky: lane overflow or group dropped at a full buffer
module depth_feature_packer
  import npu_feature_pkg::*;
#(
  parameter int RD_LAT = 1
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              i_start,
  input  logic [ADDR_W-1:0] i_d_addr,
  input  logic              i_rd_en,
  input  logic              i_pad_en,
  input  logic              i_feature_end,
  output logic [ADDR_W-1:0] o_buf_addr,
  output logic              o_buf_rd_en,
  input  logic [DATA_W-1:0] i_buf_rdata,
  output logic [VEC_W-1:0]  o_vec_data,
  output logic [3:0]        o_vec_lanes,
  output logic              o_vec_valid,
  input  logic              i_vec_ready,
  output logic              o_full,
  output logic              o_err
);

  logic              w_tag_beat, w_tag_pad, w_tag_end;
  fill_state_t       r_state, w_state_next;
  logic [CNT_W-1:0]  r_cnt, w_base_cnt, w_cnt_next;
  logic              w_commit, w_beat_ok, w_push, w_pop, w_err_set;
  logic [DATA_W-1:0] w_lane_value;
  logic [VEC_W-1:0]  w_fill_vec;
  logic [1:0]        r_occ, w_occ_next;
  logic              r_wr_ptr, r_rd_ptr, r_full, r_err;
  logic [VEC_W-1:0]  w_head_data;
  logic [CNT_W-1:0]  w_head_lanes;

  assign o_buf_addr  = i_d_addr;
  assign o_buf_rd_en = i_rd_en & ~i_pad_en;

  feature_tag_delay #(.RD_LAT(RD_LAT)) u_tag (
    .clk     (clk),
    .rst     (rst),
    .i_flush (i_start),
    .i_beat  (i_rd_en),
    .i_pad   (i_rd_en & i_pad_en),
    .i_end   (i_feature_end),
    .o_beat  (w_tag_beat),
    .o_pad   (w_tag_pad),
    .o_end   (w_tag_end)
  );

  // In COMMIT the fill register is being emptied, so a beat of the next group
  // arriving in that same cycle lands in lane 0 of the fresh group.
  assign w_commit     = (r_state == COMMIT);
  assign w_base_cnt   = w_commit ? '0 : r_cnt;
  assign w_beat_ok    = w_tag_beat && (w_base_cnt < CNT_W'(PE_COL_NUM));
  assign w_cnt_next   = w_base_cnt + CNT_W'(w_beat_ok);
  assign w_lane_value = w_tag_pad ? '0 : i_buf_rdata;

  // Next state uses the count after the beat is applied, so a beat and an
  // end in the same cycle commit that beat too.
  always_comb begin
    w_state_next = COLLECT;
    w_err_set    = 1'b0;
    if (w_tag_end && (w_cnt_next != '0)) begin
      w_state_next = COMMIT;
    end
    if (w_tag_beat && !w_beat_ok) begin
      w_err_set = 1'b1;
    end
    if (w_commit && !w_push) begin
      w_err_set = 1'b1;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state <= COLLECT;
    end else if (i_start) begin
      r_state <= COLLECT;
    end else begin
      r_state <= w_state_next;
    end
  end

  // Lane demux: each lane captures only when the fill pointer selects it.
  generate
    for (genvar gi = 0; gi < PE_COL_NUM; gi++) begin : g_lane
      logic [DATA_W-1:0] r_lane;
      always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
          r_lane <= '0;
        end else if (i_start) begin
          r_lane <= '0;
        end else if (w_beat_ok && (w_base_cnt == CNT_W'(gi))) begin
          r_lane <= w_lane_value;
        end else if (w_commit) begin
          r_lane <= '0;
        end
      end
      assign w_fill_vec[gi*DATA_W +: DATA_W] = r_lane;
    end
  endgenerate

  // Slot buffer. When full, a simultaneous pop frees the head slot, which is
  // exactly where the write pointer points, so push+pop at full is safe.
  assign w_pop      = (r_occ != 2'd0) && i_vec_ready;
  assign w_push     = w_commit && ((r_occ != 2'd2) || w_pop);
  assign w_occ_next = r_occ + {1'b0, w_push} - {1'b0, w_pop};

  generate
    for (genvar gi = 0; gi < 2; gi++) begin : g_slot
      logic [VEC_W-1:0] r_data;
      logic [CNT_W-1:0] r_lanes;
      always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
          r_data  <= '0;
          r_lanes <= '0;
        end else if (!i_start && w_push && (r_wr_ptr == 1'(gi))) begin
          r_data  <= w_fill_vec;
          r_lanes <= r_cnt;
        end
      end
    end
  endgenerate

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_cnt    <= '0;
      r_occ    <= '0;
      r_wr_ptr <= 1'b0;
      r_rd_ptr <= 1'b0;
      r_full   <= 1'b0;
      r_err    <= 1'b0;
    end else if (i_start) begin
      r_cnt    <= '0;
      r_occ    <= '0;
      r_wr_ptr <= 1'b0;
      r_rd_ptr <= 1'b0;
      r_full   <= 1'b0;
      r_err    <= 1'b0;
    end else begin
      r_cnt  <= w_cnt_next;
      r_occ  <= w_occ_next;
      r_full <= (w_occ_next == 2'd2);
      if (w_push) r_wr_ptr <= ~r_wr_ptr;
      if (w_pop)  r_rd_ptr <= ~r_rd_ptr;
      if (w_err_set) r_err <= 1'b1;
    end
  end

  assign w_head_data  = r_rd_ptr ? g_slot[1].r_data  : g_slot[0].r_data;
  assign w_head_lanes = r_rd_ptr ? g_slot[1].r_lanes : g_slot[0].r_lanes;

  assign o_vec_valid = (r_occ != 2'd0);
  assign o_vec_data  = o_vec_valid ? w_head_data  : '0;
  assign o_vec_lanes = o_vec_valid ? w_head_lanes : '0;
  assign o_full      = r_full;
  assign o_err       = r_err;

endmodule

// File: tb/tb_depth_feature_packer.sv
module tb_depth_feature_packer;
  import npu_feature_pkg::*;

  typedef struct packed {
    logic [VEC_W-1:0] d;
    logic [3:0]       l;
  } exp_t;

  logic              clk = 1'b0;
  logic              rst = 1'b1;
  logic              start = 1'b0;
  logic [ADDR_W-1:0] addr = '0;
  logic              rd_en = 1'b0;
  logic              pad = 1'b0;
  logic              fend = 1'b0;
  logic              ready1 = 1'b1;
  logic              ready3 = 1'b1;

  logic [ADDR_W-1:0] buf_addr1, buf_addr3;
  logic              buf_rd1, buf_rd3;
  logic [DATA_W-1:0] rdata1, rdata3;
  logic [VEC_W-1:0]  vdata1, vdata3;
  logic [3:0]        vlanes1, vlanes3;
  logic              valid1, valid3, full1, full3, err1, err3;

  int n_vec = 0;
  int n_err = 0;
  int cyc = 0;
  int rd_pulses = 0;
  bit mon3_en = 1'b0;
  exp_t q1[$];
  exp_t q3[$];
  exp_t e1, e3;

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  depth_feature_packer #(.RD_LAT(1)) u_dut1 (
    .clk(clk), .rst(rst), .i_start(start), .i_d_addr(addr), .i_rd_en(rd_en),
    .i_pad_en(pad), .i_feature_end(fend), .o_buf_addr(buf_addr1), .o_buf_rd_en(buf_rd1),
    .i_buf_rdata(rdata1), .o_vec_data(vdata1), .o_vec_lanes(vlanes1), .o_vec_valid(valid1),
    .i_vec_ready(ready1), .o_full(full1), .o_err(err1)
  );

  depth_feature_packer #(.RD_LAT(3)) u_dut3 (
    .clk(clk), .rst(rst), .i_start(start), .i_d_addr(addr), .i_rd_en(rd_en),
    .i_pad_en(pad), .i_feature_end(fend), .o_buf_addr(buf_addr3), .o_buf_rd_en(buf_rd3),
    .i_buf_rdata(rdata3), .o_vec_data(vdata3), .o_vec_lanes(vlanes3), .o_vec_valid(valid3),
    .i_vec_ready(ready3), .o_full(full3), .o_err(err3)
  );

  // IO-buffer model: data = low byte of the address, 0xEE when not strobed.
  logic [ADDR_W-1:0] a1_d;
  logic              s1_d;
  logic [ADDR_W-1:0] a3_d [3];
  logic              s3_d [3];
  always @(posedge clk) begin
    a1_d    <= buf_addr1;
    s1_d    <= buf_rd1;
    a3_d[0] <= buf_addr3;
    s3_d[0] <= buf_rd3;
    a3_d[1] <= a3_d[0];
    s3_d[1] <= s3_d[0];
    a3_d[2] <= a3_d[1];
    s3_d[2] <= s3_d[1];
  end
  assign rdata1 = s1_d    ? a1_d[7:0]    : 8'hEE;
  assign rdata3 = s3_d[2] ? a3_d[2][7:0] : 8'hEE;

  always @(negedge clk) if (buf_rd1) rd_pulses <= rd_pulses + 1;

  // Scoreboard: every accepted group is compared with the oldest expectation.
  always @(negedge clk) begin
    if (!rst && valid1 && ready1) begin
      n_vec++;
      if (q1.size() == 0) begin
        n_err++;
        $display("FAIL dut1_unexpected_group data=%h lanes=%0d required=none", vdata1, vlanes1);
      end else begin
        e1 = q1.pop_front();
        if (vdata1 !== e1.d || vlanes1 !== e1.l) begin
          n_err++;
          $display("FAIL dut1_group data=%h lanes=%0d required data=%h lanes=%0d", vdata1, vlanes1, e1.d, e1.l);
        end else begin
          $display("dut1 group data=%h lanes=%0d ok", vdata1, vlanes1);
        end
      end
    end
    if (!rst && mon3_en && valid3 && ready3) begin
      n_vec++;
      if (q3.size() == 0) begin
        n_err++;
        $display("FAIL dut3_unexpected_group data=%h lanes=%0d required=none", vdata3, vlanes3);
      end else begin
        e3 = q3.pop_front();
        if (vdata3 !== e3.d || vlanes3 !== e3.l) begin
          n_err++;
          $display("FAIL dut3_group data=%h lanes=%0d required data=%h lanes=%0d", vdata3, vlanes3, e3.d, e3.l);
        end else begin
          $display("dut3 group data=%h lanes=%0d ok", vdata3, vlanes3);
        end
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic send_beat(input logic [ADDR_W-1:0] a, input logic p);
    rd_en = 1'b1;
    pad   = p;
    addr  = a;
    tick();
    rd_en = 1'b0;
    pad   = 1'b0;
  endtask

  task automatic send_end();
    fend = 1'b1;
    tick();
    fend = 1'b0;
  endtask

  task automatic pulse_start();
    start = 1'b1;
    tick();
    start = 1'b0;
  endtask

  task automatic wait_drain(input int budget, output bit ok);
    ok = 1'b0;
    for (int i = 0; i < budget; i++) begin
      @(negedge clk);
      if (q1.size() == 0 && (!mon3_en || q3.size() == 0)) begin
        ok = 1'b1;
        break;
      end
    end
    tick();
  endtask

  task automatic test_reset();
    bit seen;
    rd_en = 1'b1;
    addr  = 13'h123;
    repeat (3) @(posedge clk);
    #2;
    n_vec++;
    if (buf_rd1 !== 1'b1 || buf_addr1 !== 13'h123) begin
      n_err++;
      $display("FAIL reset_buf_passthrough rd=%b addr=%h required rd=1 addr=123", buf_rd1, buf_addr1);
    end
    n_vec++;
    if (valid1 !== 1'b0 || vdata1 !== '0 || vlanes1 !== 4'd0 || full1 !== 1'b0 || err1 !== 1'b0) begin
      n_err++;
      $display("FAIL reset_outputs valid=%b data=%h lanes=%0d full=%b err=%b required all zero",
               valid1, vdata1, vlanes1, full1, err1);
    end
    rd_en = 1'b0;
    addr  = '0;
    @(negedge clk);
    rst = 1'b0;
    tick();
    // Mid-run reset: a held group and a partial group must vanish at once.
    ready1 = 1'b0;
    send_beat(13'h061, 1'b0);
    send_end();
    seen = 1'b0;
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      if (valid1) begin
        seen = 1'b1;
        break;
      end
    end
    n_vec++;
    if (!seen) begin
      n_err++;
      $display("FAIL reset_pre_group valid=0 required=1 within 10 cycles");
    end
    send_beat(13'h062, 1'b0);
    rst = 1'b1;
    #1;
    n_vec++;
    if (valid1 !== 1'b0 || vdata1 !== '0 || vlanes1 !== 4'd0) begin
      n_err++;
      $display("FAIL reset_async valid=%b data=%h lanes=%0d required 0/0/0", valid1, vdata1, vlanes1);
    end
    #1;
    rst = 1'b0;
    repeat (4) tick();
    n_vec++;
    if (valid1 !== 1'b0 || err1 !== 1'b0) begin
      n_err++;
      $display("FAIL reset_after valid=%b err=%b required 0/0", valid1, err1);
    end
    ready1 = 1'b1;
  endtask

  task automatic test_full_group();
    logic [VEC_W-1:0] v;
    int t0;
    int tv;
    bit ok;
    v  = '0;
    t0 = cyc;
    for (int i = 0; i < 8; i++) begin
      send_beat(ADDR_W'(8'h11 * (i + 1)), 1'b0);
      v[i*8 +: 8] = 8'(8'h11 * (i + 1));
    end
    q1.push_back('{d: v, l: 4'd8});
    send_end();
    tv = -1;
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      if (valid1) begin
        tv = cyc;
        break;
      end
    end
    n_vec++;
    if (tv - t0 != 11) begin
      n_err++;
      $display("FAIL full_group_latency valid_cycle=%0d required=11", tv - t0);
    end
    wait_drain(20, ok);
    n_vec++;
    if (!ok || v !== 64'h8877665544332211) begin
      n_err++;
      $display("FAIL full_group_drain drained=%b required=1", ok);
    end
  endtask

  task automatic test_pad_short();
    int p0;
    bit ok;
    p0 = rd_pulses;
    send_beat(13'h0AA, 1'b1);
    send_beat(13'h0AA, 1'b0);
    send_beat(13'h0AA, 1'b0);
    send_beat(13'h0AA, 1'b0);
    send_beat(13'h0AA, 1'b1);
    q1.push_back('{d: 64'h00000000_00AAAAAA00, l: 4'd5});
    send_end();
    n_vec++;
    if (rd_pulses - p0 != 3) begin
      n_err++;
      $display("FAIL pad_rd_pulses count=%0d required=3", rd_pulses - p0);
    end
    wait_drain(20, ok);
    n_vec++;
    if (!ok) begin
      n_err++;
      $display("FAIL pad_drain drained=0 required=1");
    end
  endtask

  task automatic test_backpressure();
    bit ok;
    ready1 = 1'b0;
    send_beat(13'h001, 1'b0);
    send_beat(13'h002, 1'b0);
    send_end();
    send_beat(13'h003, 1'b0);
    send_beat(13'h004, 1'b0);
    send_end();
    q1.push_back('{d: 64'h0201, l: 4'd2});
    q1.push_back('{d: 64'h0403, l: 4'd2});
    repeat (4) tick();
    n_vec++;
    if (full1 !== 1'b1 || err1 !== 1'b0) begin
      n_err++;
      $display("FAIL bp_two_groups full=%b err=%b required 1/0", full1, err1);
    end
    send_beat(13'h005, 1'b0);
    send_end();
    repeat (4) tick();
    n_vec++;
    if (full1 !== 1'b1 || err1 !== 1'b1) begin
      n_err++;
      $display("FAIL bp_third_drop full=%b err=%b required 1/1", full1, err1);
    end
    ready1 = 1'b1;
    wait_drain(20, ok);
    tick();
    n_vec++;
    if (!ok || valid1 !== 1'b0 || full1 !== 1'b0 || err1 !== 1'b1) begin
      n_err++;
      $display("FAIL bp_after_drain drained=%b valid=%b full=%b err=%b required 1/0/0/1",
               ok, valid1, full1, err1);
    end
    pulse_start();
    n_vec++;
    if (err1 !== 1'b0) begin
      n_err++;
      $display("FAIL bp_start_clears_err err=%b required=0", err1);
    end
  endtask

  task automatic test_push_pop();
    bit ok;
    ready1 = 1'b0;
    send_beat(13'h021, 1'b0);
    send_end();
    send_beat(13'h022, 1'b0);
    send_end();
    repeat (3) tick();
    send_beat(13'h023, 1'b0);
    q1.push_back('{d: 64'h21, l: 4'd1});
    q1.push_back('{d: 64'h22, l: 4'd1});
    q1.push_back('{d: 64'h23, l: 4'd1});
    fend = 1'b1;
    tick();              // end in cycle e
    fend = 1'b0;
    tick();              // cycle e+2: COMMIT, pop together with push
    ready1 = 1'b1;
    tick();
    ready1 = 1'b0;
    tick();
    n_vec++;
    if (full1 !== 1'b1 || err1 !== 1'b0 || valid1 !== 1'b1) begin
      n_err++;
      $display("FAIL push_pop_full full=%b err=%b valid=%b required 1/0/1", full1, err1, valid1);
    end
    ready1 = 1'b1;
    wait_drain(20, ok);
    n_vec++;
    if (!ok || err1 !== 1'b0) begin
      n_err++;
      $display("FAIL push_pop_drain drained=%b err=%b required 1/0", ok, err1);
    end
  endtask

  task automatic test_overlong();
    logic [VEC_W-1:0] v;
    bit ok;
    v = '0;
    for (int i = 0; i < 9; i++) begin
      send_beat(ADDR_W'(8'h31 + i), 1'b0);
      if (i < 8) v[i*8 +: 8] = 8'(8'h31 + i);
    end
    q1.push_back('{d: v, l: 4'd8});
    send_end();
    wait_drain(20, ok);
    n_vec++;
    if (!ok || err1 !== 1'b1) begin
      n_err++;
      $display("FAIL overlong drained=%b err=%b required 1/1", ok, err1);
    end
    pulse_start();
  endtask

  task automatic test_flush();
    int stray;
    bit ok;
    ready1 = 1'b1;
    ready3 = 1'b1;
    pulse_start();
    mon3_en = 1'b1;
    for (int i = 0; i < 4; i++) send_beat(ADDR_W'(8'h41 + i), 1'b0);
    send_end();
    pulse_start();
    stray = 0;
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      if (valid1 || valid3) stray++;
    end
    n_vec++;
    if (stray != 0) begin
      n_err++;
      $display("FAIL flush_no_group valid_cycles=%0d required=0", stray);
    end
    tick();
    for (int i = 0; i < 3; i++) send_beat(ADDR_W'(8'h51 + i), 1'b0);
    q1.push_back('{d: 64'h535251, l: 4'd3});
    q3.push_back('{d: 64'h535251, l: 4'd3});
    send_end();
    wait_drain(30, ok);
    n_vec++;
    if (!ok || err1 !== 1'b0 || err3 !== 1'b0) begin
      n_err++;
      $display("FAIL flush_next_group drained=%b err1=%b err3=%b required 1/0/0", ok, err1, err3);
    end
    mon3_en = 1'b0;
  endtask

  initial begin
    test_reset();
    test_full_group();
    test_pad_short();
    test_backpressure();
    test_push_pop();
    test_overlong();
    test_flush();
    n_vec++;
    if (q1.size() != 0 || q3.size() != 0) begin
      n_err++;
      $display("FAIL leftover_expected q1=%0d q3=%0d required 0/0", q1.size(), q3.size());
    end
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL global_timeout reached 200000 time units");
    $fatal(1);
  end

endmodule

// File: doc/depth_feature_packer.md
# depth_feature_packer

Sits directly downstream of the depthwise-convolution input address generator and upstream of the PE array. Each read beat (address, read enable, pad flag) is turned into an IO-buffer read, or into a zero when the beat is padding. Returned features are collected lane by lane into a PE_COL_NUM-wide group vector. When the end-of-group marker arrives, the group is committed and handed to the PE array through a two-entry valid/ready buffer.

## Interface
- PE_COL_NUM, 8, lanes per group; equals the number of parallel PE columns
- DATA_W, 8, feature width in bits
- ADDR_W, 13, IO-buffer address width
- RD_LAT, 1, IO-buffer read latency in cycles, from address to data; legal range 1–4
- clk  in  1  clock
- rst  in  1  asynchronous, active-high reset
- i_start  in  1  start_calculate from the scheduler; synchronous flush
- i_d_addr  in  ADDR_W  beat address from the address generator
- i_rd_en  in  1  beat valid; one lane per high cycle
- i_pad_en  in  1  beat is padding; qualified by i_rd_en
- i_feature_end  in  1  one-cycle end-of-group pulse, arriving after the group's last beat
- o_buf_addr  out  ADDR_W  IO-buffer read address
- o_buf_rd_en  out  1  IO-buffer read strobe
- i_buf_rdata  in  DATA_W  IO-buffer read data, valid RD_LAT cycles after the strobe
- o_vec_data  out  PE_COL_NUM*DATA_W  group vector; lane 0 in the LSBs
- o_vec_lanes  out  4  number of filled lanes, 1..PE_COL_NUM
- o_vec_valid  out  1  group available
- i_vec_ready  in  1  PE array accepts the group
- o_full  out  1  both buffer slots occupied
- o_err  out  1  sticky error flag; cleared by rst or i_start

## Operation
- o_buf_addr = i_d_addr and o_buf_rd_en = i_rd_en & ~i_pad_en, both combinational. Padding beats never read the buffer.
- Tag pipeline, RD_LAT stages deep, carries three fields:
  - {beat, pad}, where beat = i_rd_en
  - end = i_feature_end
- Fill FSM:
  - COLLECT: the pipeline output beat writes lane `fill_cnt` of the fill register. The written value is i_buf_rdata, or 0 when pad. Then fill_cnt increments.
  - A beat arriving when fill_cnt == PE_COL_NUM is dropped and sets o_err.
  - The pipeline output end moves to COMMIT when fill_cnt > 0. With fill_cnt == 0 it is ignored.
  - COMMIT, one cycle: push {fill register, fill_cnt} into the slot buffer, clear the fill register to zeros, set fill_cnt to 0, return to COLLECT.
  - If both slots are full at commit and no pop happens in the same cycle, the group is dropped and o_err is set.
  - A beat and an end at the pipeline output in the same cycle: the beat is written first, then the end is applied.
- Slot buffer: 2 entries, FIFO order, with 2-bit occupancy. Pop when o_vec_valid & i_vec_ready. Push and pop in the same cycle leave the count unchanged, including when full.
- o_vec_valid = occupancy != 0. o_vec_data and o_vec_lanes show the head slot and stay stable while valid is high and ready is low.
- Unfilled lanes are zero.
- i_start clears the fill register, fill_cnt, the tag pipeline, the slots and o_err in one cycle. Beats in flight are discarded.
- rst (any time, including mid-group) clears everything.
- Output values under rst: o_vec_valid=0, o_vec_data=0, o_vec_lanes=0, o_full=0, o_err=0. o_buf_* follow the inputs.

## Timing
- A beat issued in cycle t lands in the fill register at the end of cycle t+RD_LAT.
- An end pulse in cycle e is seen by COMMIT in cycle e+RD_LAT+1. o_vec_valid rises in cycle e+RD_LAT+2.
  - With RD_LAT=1: 8 beats in cycles 0–7, end in cycle 8, valid from cycle 11.
- Back-to-back: the next group's beats may start in cycle e+1. Pipeline ordering guarantees the next group's beats never hit the fill register before COMMIT completes.
- A pop takes effect at the clock edge. o_vec_valid falls in the next cycle if the buffer becomes empty.
- o_full is registered and is high exactly when occupancy == 2.

## Structure
- Shared package npu_feature_pkg holds:
  - PE_COL_NUM, DATA_W, ADDR_W
  - the fill FSM state enum (COLLECT, COMMIT)
- Sub-module feature_tag_delay: an RD_LAT-deep shift register for {beat, pad, end}, with synchronous flush.
- The top-level block holds the fill FSM, the lane demux and the 2-slot buffer.

## Test plan
- Full group: 8 beats, no pad, data 0x11..0x88, RD_LAT=1, ready=1 -> valid in cycle 11, lanes=8, vector 0x8877665544332211.
- Pad and short group: 5 beats with lanes 0 and 4 padded, reads return 0xAA -> o_buf_rd_en pulses 3 times, lanes=5, vector 0x00AAAAAA00 with upper lanes 0.
- Backpressure: ready held at 0 across three groups -> o_full after the second group, o_err set at the third commit, the first two groups are delivered intact in order.
- Push and pop together: buffer full, pop in the commit cycle -> no error, occupancy stays 2.
- Overlong group: 9 beats before end -> 8 lanes delivered, o_err=1.
- Flush: i_start asserted mid-group with RD_LAT=3 -> no group emitted; the next group is clean, lanes start at 0.
